// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the MEM stage, feeding the MEM/WB register.
// Byte, halfword and word accesses use little-endian lanes with sign or zero
// extension. Requests go out over a req/gnt/rvalid bus and the pipeline stalls
// while they are in flight. Misaligned accesses are reported and not issued.
// Optional: define MEM_LSU_TIMEOUT_EN to add a bus watchdog that aborts a
// transaction after TIMEOUT_CYC cycles and pulses buserr_o.
module mem_lsu #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            lsu_op_i,
   input  logic [31:0]           store_data_i,
   output logic                  stall_o,
   output logic                  dreq_o,
   output logic                  dwe_o,
   output logic [ADDR_W-1:0]     daddr_o,
   output logic [3:0]            dbe_o,
   output logic [31:0]           dwdata_o,
   input  logic                  dgnt_i,
   input  logic                  drvalid_i,
   input  logic [31:0]           drdata_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  valid_o,
   output logic                  misalign_o,
   output logic                  buserr_o
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Halfwords need bit 0 clear, words need both low bits clear.
   function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
      logic mis;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = a[0];
         OP_LW, OP_SW:         mis = (a != 2'b00);
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Loads and word stores enable every lane.
   function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] a);
      logic [3:0] be;
      case (op)
         OP_SB:   be = 4'b0001 << a;
         OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Narrow stores are replicated so the enabled lane always carries the data.
   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sd);
      logic [31:0] d;
      case (op)
         OP_SB:   d = {4{sd[7:0]}};
         OP_SH:   d = {2{sd[15:0]}};
         default: d = sd;
      endcase
      return d;
   endfunction

   // Select the addressed lane(s) of the read word and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                input logic [31:0] rd);
      logic signed [7:0]  b8;
      logic signed [15:0] h16;
      logic [31:0]        res;
      b8  = rd[{a, 3'b000} +: 8];
      h16 = a[1] ? rd[31:16] : rd[15:0];
      case (op)
         OP_LB:   res = 32'(b8);
         OP_LBU:  res = {24'h000000, unsigned'(b8)};
         OP_LH:   res = 32'(h16);
         OP_LHU:  res = {16'h0000, unsigned'(h16)};
         default: res = rd;
      endcase
      return res;
   endfunction

   state_t                  state_p1, state_p0;
   logic                    stall_c;
   logic                    vld_p0, wreg_p0, mis_p0, berr_p0;
   logic [REG_ADDR_W-1:0]   wd_p0;
   logic [31:0]             wdata_p0;
   logic                    dreq_p0, dwe_p0;
   logic [ADDR_W-1:0]       daddr_p0;
   logic [3:0]              dbe_p0;
   logic [31:0]             dwdata_p0;
   logic                    wdog_hit;

`ifdef MEM_LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] wdog_cnt_p1;

   // The count reads N-1 during the Nth cycle in a bus state, so the limit fires in cycle TIMEOUT_CYC.
   assign wdog_hit = (wdog_cnt_p1 == CNT_W'(TIMEOUT_CYC - 1));

   // Watchdog: restart on entry to REQ/WAIT, count each cycle spent there, saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_p1 <= '0;
      end else if ((state_p0 != state_p1) && (state_p0 != S_IDLE)) begin
         wdog_cnt_p1 <= '0;
      end else if ((state_p1 != S_IDLE) && (wdog_cnt_p1 != '1)) begin
         wdog_cnt_p1 <= wdog_cnt_p1 + CNT_W'(1);
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   // Next state, next MEM/WB/bus register contents and the combinational stall.
   always_comb begin
      state_p0  = state_p1;
      stall_c   = 1'b0;
      vld_p0    = 1'b0;
      wreg_p0   = 1'b0;
      mis_p0    = 1'b0;
      berr_p0   = 1'b0;
      wd_p0     = wd_o;
      wdata_p0  = wdata_o;
      dreq_p0   = dreq_o;
      dwe_p0    = dwe_o;
      daddr_p0  = daddr_o;
      dbe_p0    = dbe_o;
      dwdata_p0 = dwdata_o;
      case (state_p1)
         S_IDLE: begin
            if (valid_i) begin
               if (!op_is_load(lsu_op_i) && !op_is_store(lsu_op_i)) begin
                  vld_p0   = 1'b1;
                  wreg_p0  = wreg_i;
                  wd_p0    = wd_i;
                  wdata_p0 = wdata_i;
               end else if (op_misaligned(lsu_op_i, wdata_i[1:0])) begin
                  vld_p0   = 1'b1;
                  mis_p0   = 1'b1;
                  wd_p0    = wd_i;
                  wdata_p0 = wdata_i;
               end else begin
                  stall_c   = 1'b1;
                  dreq_p0   = 1'b1;
                  dwe_p0    = op_is_store(lsu_op_i);
                  daddr_p0  = {wdata_i[ADDR_W-1:2], 2'b00};
                  dbe_p0    = store_be(lsu_op_i, wdata_i[1:0]);
                  dwdata_p0 = store_data(lsu_op_i, store_data_i);
                  state_p0  = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (dgnt_i) begin
               dreq_p0 = 1'b0;
               if (dwe_o) begin
                  vld_p0   = 1'b1;
                  state_p0 = S_IDLE;
               end else begin
                  stall_c  = 1'b1;
                  state_p0 = S_WAIT;
               end
            end else if (wdog_hit) begin
               dreq_p0  = 1'b0;
               vld_p0   = 1'b1;
               berr_p0  = 1'b1;
               state_p0 = S_IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         S_WAIT: begin
            if (drvalid_i) begin
               vld_p0   = 1'b1;
               wreg_p0  = wreg_i;
               wd_p0    = wd_i;
               wdata_p0 = load_extract(lsu_op_i, wdata_i[1:0], drdata_i);
               state_p0 = S_IDLE;
            end else if (wdog_hit) begin
               vld_p0   = 1'b1;
               berr_p0  = 1'b1;
               state_p0 = S_IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         default: begin
            state_p0 = S_IDLE;
         end
      endcase
   end

   // Keep the pipeline free while reset is held so every output reads 0.
   assign stall_o = rst_n & stall_c;

   // MEM/WB register, bus request register and FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1   <= S_IDLE;
         valid_o    <= 1'b0;
         wreg_o     <= 1'b0;
         misalign_o <= 1'b0;
         buserr_o   <= 1'b0;
         wd_o       <= '0;
         wdata_o    <= '0;
         dreq_o     <= 1'b0;
         dwe_o      <= 1'b0;
         daddr_o    <= '0;
         dbe_o      <= '0;
         dwdata_o   <= '0;
      end else begin
         state_p1   <= state_p0;
         valid_o    <= vld_p0;
         wreg_o     <= wreg_p0;
         misalign_o <= mis_p0;
         buserr_o   <= berr_p0;
         wd_o       <= wd_p0;
         wdata_o    <= wdata_p0;
         dreq_o     <= dreq_p0;
         dwe_o      <= dwe_p0;
         daddr_o    <= daddr_p0;
         dbe_o      <= dbe_p0;
         dwdata_o   <= dwdata_p0;
      end
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised successor to the MEM pipeline stage; sits between EX/MEM and MEM/WB.
- Adds byte, halfword and word loads/stores with sign or zero extension and byte-enable generation.
- Drives a request/grant/rvalid data-bus handshake with a pipeline stall, and detects misaligned accesses.
- Outputs are registered and form the MEM/WB register.

Parameters:
ADDR_W, 32, data-bus address width (at least 3)
REG_ADDR_W, 5, destination register index width
TIMEOUT_CYC, 255, watchdog limit in cycles; used only with MEM_LSU_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
valid_i  in  1  EX/MEM slot holds a valid instruction
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  ALU result; the effective address for memory ops
lsu_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
store_data_i  in  32  store source (rt)
stall_o  out  1  hold EX/MEM and all earlier stages
dreq_o  out  1  bus request
dwe_o  out  1  1 = write
daddr_o  out  ADDR_W  word-aligned address {wdata_i[ADDR_W-1:2],2'b00}
dbe_o  out  4  byte enables
dwdata_o  out  32  write data
dgnt_i  in  1  request accepted
drvalid_i  in  1  read data valid
drdata_i  in  32  read data
wd_o  out  REG_ADDR_W  to MEM/WB
wreg_o  out  1  to MEM/WB
wdata_o  out  32  to MEM/WB
valid_o  out  1  MEM/WB slot valid
misalign_o  out  1  one-cycle misaligned-access pulse
buserr_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE; this applies mid-transaction too, so dreq_o drops immediately.
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid_i=0: next edge valid_o=0, wreg_o=0.
- IDLE, NONE op: next edge registers wd_i, wreg_i, wdata_i and valid_o=1 (latency 1); stall_o=0.
- IDLE, aligned memory op: stall_o=1 combinationally. Next edge registers dreq_o=1, dwe_o, daddr_o, dbe_o, dwdata_o, goes to REQ, and sets valid_o=0.
- IDLE, misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no request, stall_o=0. Next edge: valid_o=1, wreg_o=0, misalign_o=1.
- REQ: dreq_o and the bus fields are held stable until dgnt_i.
  - Grant on a load: dreq_o=0, go to WAIT; stall_o stays 1.
  - Grant on a store: stall_o=0 that cycle. Next edge: dreq_o=0, valid_o=1, wreg_o=0, back to IDLE.
- WAIT: stall_o = !drvalid_i.
  - On drvalid_i, next edge: wdata_o = extracted data, wreg_o=wreg_i, wd_o=wd_i, valid_o=1, back to IDLE.
  - drvalid_i is legal no earlier than the cycle after dgnt_i; drvalid_i outside WAIT is ignored.
- Upstream holds all inputs stable while stall_o=1.
- Byte lanes are little-endian: byte k is drdata_i[8k+7:8k], k = addr[1:0].
  - LB/LBU: lane k, sign/zero extended.
  - LH/LHU: lanes {k+1,k}, k in {0,2}.
  - LW: full word.
- Stores:
  - SB: dbe = 1<<k, byte replicated on all 4 lanes.
  - SH: dbe = 0011 or 1100, halfword replicated on both halves.
  - SW: dbe = 1111.
  - Loads drive dbe=1111 and dwe=0.
- valid_o, misalign_o and buserr_o last exactly one cycle per instruction.

Optional Feature:
MEM_LSU_TIMEOUT_EN
- Defined: an 8+ bit counter clears on entering REQ or WAIT and increments every cycle spent there.
  - When it reaches TIMEOUT_CYC without dgnt_i/drvalid_i, next edge: dreq_o=0, IDLE, valid_o=1, wreg_o=0, buserr_o=1.
  - stall_o=0 in the abort cycle.
  - A grant or rvalid arriving in the same cycle the limit is reached wins over the timeout.
- Undefined: no counter; the FSM waits indefinitely and buserr_o is tied 0.

Test Plan:
1. Reset asserted while in REQ with dreq_o=1 -> dreq_o=0 asynchronously; all outputs 0; after release the FSM is IDLE.
2. NONE op, wd_i=5, wreg_i=1, wdata_i=0x1234 -> one cycle later wd_o=5, wreg_o=1, wdata_o=0x1234, valid_o=1, stall_o never 1.
3. LB at addr 0x103, dgnt_i after 2 cycles, drvalid_i next cycle with drdata_i=0x80FF0011 -> daddr_o=0x100, wdata_o=0xFFFFFF80; same with LBU -> 0x00000080; stall_o high from accept until the drvalid_i cycle.
4. SH at addr 0x202, store_data_i=0xAAAABEEF, immediate grant -> dbe_o=1100, dwdata_o=0xBEEFBEEF, dwe_o=1, then valid_o=1, wreg_o=0.
5. LW at addr 0x6 -> no dreq_o; misalign_o=1 for one cycle, wreg_o=0, stall_o=0.
6. With MEM_LSU_TIMEOUT_EN and TIMEOUT_CYC=4, dgnt_i held 0 -> abort after 4 cycles in REQ, buserr_o=1, dreq_o=0; without the macro dreq_o stays high.
